fir_sample_feeder: RTL and testbench
====================================

// Module: fir_sample_feeder
// PURPOSE
//  Upstream stage of the 8-bit FIR filter. Accepts signed samples from a source over a valid/ready handshake.
//  Buffers them in a FIFO and drives the filter's input_sig/ready pair.
//  The filter consumes one sample every FRAME_LEN cycles while its ready is high, and shifts every cycle while ready is low.
//  This block therefore keeps fir_ready high continuously in RUN and changes fir_sig only on frame boundaries.
// PARAMETERS
//  FRAME_LEN    20  clocks per filter sample period (filter taps/4); load cycle = count FRAME_LEN-1
//  DEPTH        16  FIFO depth in samples, power of 2, >=2
//  FLUSH_CYCLES 80  clocks with fir_ready=0, fir_sig=0 after reset; clears the filter delay line
// PORTS
//  clk          in   1  clock, all logic on posedge
//  rst          in   1  asynchronous, active-high reset
//  s_data       in   8  signed source sample
//  s_valid      in   1  s_data valid
//  s_ready      out  1  FIFO can accept; transfer when s_valid & s_ready
//  fir_sig      out  8  signed sample to filter input_sig
//  fir_ready    out  1  to filter ready
//  sample_tick  out  1  1-cycle pulse on load cycle (filter latches fir_sig, updates filtred_sig)
//  underrun     out  1  1-cycle pulse: load cycle found FIFO empty
//  level        out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset values: fir_sig=0, fir_ready=0, sample_tick=0, underrun=0, level=0, s_ready=0 while rst high.
//  FSM FLUSH -> RUN:
//   - FLUSH: fir_ready=0, fir_sig=0; counts FLUSH_CYCLES clocks, then enters RUN.
//   - FIFO accepts pushes during FLUSH.
//   - RUN: fir_ready=1 every cycle; frame counter 0..FRAME_LEN-1, wraps to 0; never leaves RUN except via rst.
//  Counter starts at 0 on the first RUN cycle. This aligns with the filter's internal index, which is forced to 0 while its ready is low.
//  Load cycle (RUN & count==FRAME_LEN-1):
//   - sample_tick=1 (combinational from registered state).
//   - At the ending edge, fir_sig <= FIFO head and the head is popped.
//   - If the FIFO is empty: fir_sig <= 0, underrun=1 for that cycle, no pop.
//  fir_sig is constant for a whole frame. It is consumed by the filter on the next frame's load cycle.
//  Latency: push-to-filter-latch is at least 1 frame and at most (level+2)*FRAME_LEN cycles.
//  s_ready = !full, computed from registered level. Full = level==DEPTH.
//  Push when full is impossible (s_ready=0). s_data is ignored without s_valid.
//  Push and pop on the same edge: level unchanged; FIFO order preserved.
//  Push onto an empty FIFO on a load edge: no bypass. The pop reports underrun and the new sample is stored.
//  Pointers wrap modulo DEPTH. level is registered and updated on the same edge as the pointers.
//  rst mid-operation: all state is cleared immediately. FIFO contents are lost and the FSM returns to FLUSH.
//  After rst deasserts, FLUSH re-zeroes the filter delay line.
// CONFIGURATION
//  HOLD_LAST_EN defined: on underrun, fir_sig keeps its previous value (last sample repeated); underrun still pulses.
//  HOLD_LAST_EN undefined: on underrun, fir_sig <= 0.
// TESTING
//  1. rst pulse, no input:
//     - fir_ready=0, fir_sig=0 for 80 clks; fir_ready=1 from clk 80.
//     - sample_tick at clk 99, 119, ...; underrun pulses on every tick.
//  2. Push 5, -3, 127 during FLUSH:
//     - fir_sig=5 after the first tick, -3 after the second, 127 after the third.
//     - level goes 3->2->1->0; no underrun until the 4th tick.
//  3. Burst of 20 samples at s_valid=1:
//     - s_ready drops after 16 accepts.
//     - s_ready rises the cycle after the first pop; data is accepted in order; no sample is lost.
//  4. Underrun after last sample -8:
//     - fir_sig=0 and underrun=1 at the next tick.
//     - With HOLD_LAST_EN, fir_sig stays -8.
//  5. Simultaneous push/pop at level=1:
//     - level stays 1; fir_sig = old head; new sample is presented on the next tick.
//  6. rst asserted mid-frame with level=7:
//     - Outputs go to 0 immediately and level=0.
//     - After release, an 80-clk FLUSH, then tick at clk 99 with underrun.

Source files
------------

// File: rtl/fir_sample_feeder_if.sv
// rtl/fir_sample_feeder_if.sv - source handshake and filter drive signals of the FIR sample feeder
interface fir_sample_feeder_if #(
    parameter int DEPTH = 16
);
    logic signed [7:0]       s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [7:0]       fir_sig;
    logic                    fir_ready;
    logic                    sample_tick;
    logic                    underrun;
    logic [$clog2(DEPTH):0]  level;

    modport master (
        output s_data, s_valid,
        input  s_ready, fir_sig, fir_ready, sample_tick, underrun, level
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, fir_sig, fir_ready, sample_tick, underrun, level
    );
endinterface

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - FIFO-buffered sample feeder for the 8-bit FIR filter (option: HOLD_LAST_EN)
module fir_sample_feeder #(
    parameter int FRAME_LEN    = 20,
    parameter int DEPTH        = 16,
    parameter int FLUSH_CYCLES = 80
) (
    input  logic              clk,
    input  logic              rst,
    fir_sample_feeder_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int FCW = $clog2(FRAME_LEN);
    localparam int FLW = $clog2(FLUSH_CYCLES);

    localparam logic [0:0] ST_FLUSH = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state;
    logic [FLW-1:0]    flush_cnt;
    logic [FCW-1:0]    frame_cnt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic signed [7:0] fir_sig;
    logic signed [7:0] mem [DEPTH];

    logic load;
    logic empty;
    logic full;
    logic push;
    logic pop;

    assign load  = (state == ST_RUN) && (frame_cnt == FCW'(FRAME_LEN - 1));
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    // s_ready is forced low while rst is high, not just after the first edge
    assign push  = bus.s_valid && !full && !rst;
    assign pop   = load && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            frame_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            fir_sig   <= '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    if (flush_cnt == FLW'(FLUSH_CYCLES - 1)) begin
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt + FLW'(1);
                    end
                end
                default: begin
                    frame_cnt <= load ? '0 : frame_cnt + FCW'(1);
                end
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (load) begin
                if (!empty) begin
                    fir_sig <= mem[rd_ptr];
                end else begin
`ifdef HOLD_LAST_EN
                    fir_sig <= fir_sig;
`else
                    fir_sig <= '0;
`endif
                end
            end
        end
    end

    // Storage is not reset; pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.s_data;
        end
    end

    assign bus.s_ready     = !full && !rst;
    assign bus.fir_sig     = fir_sig;
    assign bus.fir_ready   = (state == ST_RUN);
    assign bus.sample_tick = load;
    assign bus.underrun    = load && empty;
    assign bus.level       = level;
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - scoreboard testbench for fir_sample_feeder
module tb_fir_sample_feeder;
    localparam int FRAME_LEN    = 20;
    localparam int DEPTH        = 16;
    localparam int FLUSH_CYCLES = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_sample_feeder_if #(.DEPTH(DEPTH)) bus ();

    fir_sample_feeder #(
        .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_sig  = 0;
    int n_ticks  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge, before stimulus records this cycle's push
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                cyc     = 0;
                exp_sig = 0;
                chk("rst_fir_sig",     int'($signed(bus.fir_sig)), 0);
                chk("rst_fir_ready",   int'(bus.fir_ready), 0);
                chk("rst_sample_tick", int'(bus.sample_tick), 0);
                chk("rst_underrun",    int'(bus.underrun), 0);
                chk("rst_level",       int'(bus.level), 0);
                chk("rst_s_ready",     int'(bus.s_ready), 0);
            end else begin
                automatic bit tick = (cyc >= FLUSH_CYCLES) &&
                                     ((cyc - FLUSH_CYCLES) % FRAME_LEN == FRAME_LEN - 1);
                chk("fir_ready",   int'(bus.fir_ready), int'(cyc >= FLUSH_CYCLES));
                chk("sample_tick", int'(bus.sample_tick), int'(tick));
                chk("level",       int'(bus.level), exp_q.size());
                chk("s_ready",     int'(bus.s_ready), int'(exp_q.size() < DEPTH));
                chk("fir_sig",     int'($signed(bus.fir_sig)), exp_sig);
                chk("underrun",    int'(bus.underrun), int'(tick && exp_q.size() == 0));
                if (tick) begin
                    n_ticks++;
                    if (exp_q.size() != 0) begin
                        exp_sig = exp_q.pop_front();
                    end else begin
`ifndef HOLD_LAST_EN
                        exp_sig = 0;
`endif
                    end
                end
                cyc++;
            end
        end
    end

    task automatic drive(input bit v, input int d);
        @(negedge clk);
        bus.s_valid = v;
        bus.s_data  = 8'(d);
        #2;
        if (v && bus.s_ready) begin
            exp_q.push_back(int'($signed(8'(d))));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        exp_q.delete();
        repeat (hold) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tick();
        int i;
        i = 0;
        drive(1'b0, 0);
        while (!bus.sample_tick && i < 100) begin
            drive(1'b0, 0);
            i++;
        end
        chk("wait_tick_timeout", int'(bus.sample_tick), 1);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        do_reset(3);

        // Pushes during FLUSH, then let them drain and underrun
        drive(1'b1, 5);
        drive(1'b1, -3);
        drive(1'b1, 127);
        idle(180);

        // Burst beyond FIFO depth, then drain
        for (int i = 0; i < 40; i++) drive(1'b1, int'($urandom_range(0, 255)));
        idle(380);

        // Last sample then underrun
        drive(1'b1, -8);
        idle(60);

        // Push on the load edge with one sample already queued
        wait_tick();
        drive(1'b1, 33);
        idle(18);
        drive(1'b1, -77);
        idle(45);

        // Reset mid-frame with several samples queued
        for (int i = 0; i < 7; i++) drive(1'b1, int'($urandom_range(0, 255)));
        idle(5);
        do_reset(2);
        idle(130);

        // Random traffic at several densities
        for (int p = 0; p < 4; p++) begin
            automatic int pct = (p == 0) ? 3 : (p == 1) ? 5 : (p == 2) ? 8 : 60;
            for (int i = 0; i < 500; i++)
                drive($urandom_range(0, 99) < pct, int'($urandom_range(0, 255)));
        end
        idle(400);

        chk("tick_count_min", int'(n_ticks > 100), 1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
